lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU; consumes the ALU result as the effective byte address.
- Performs RV32I load/store byte-lane alignment, store byte-enable generation and load sign/zero extension.
- Runs the transaction on a single-outstanding req/ack data-memory port.
- Stalls the core via a busy/done handshake until the access completes or faults.

Parameters:
XLEN, 32, datapath/address width (only 32 supported)
TIMEOUT_CYCLES, 256, cycles in WAIT before bus-error abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
lsu_valid  input  1  request strobe, sampled only in IDLE
lsu_we  input  1  1=store, 0=load
lsu_funct3  input  3  RV32I size/sign field
lsu_addr  input  XLEN  effective address (ALU output)
lsu_wdata  input  XLEN  store data (rs2)
lsu_rdata  output  XLEN  extended load result, valid while lsu_done
lsu_done  output  1  one-cycle completion pulse
lsu_busy  output  1  high in any state except IDLE
lsu_misalign  output  1  with lsu_done: address misaligned for size
lsu_ill  output  1  with lsu_done: illegal funct3 for op
lsu_bus_err  output  1  with lsu_done: timeout abort (0 when macro absent)
mem_req  output  1  memory request, held until ack
mem_we  output  1  memory write enable
mem_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00})
mem_be  output  4  byte enables
mem_wdata  output  XLEN  lane-shifted store data
mem_rdata  input  XLEN  memory read word, valid with mem_ack
mem_ack  input  1  completion from memory, 1 cycle

Behaviour:
- Reset: state=IDLE; every output 0, including lsu_rdata, mem_addr, mem_be and mem_wdata.
- Reset is honoured in any state. An in-flight request is dropped and mem_req is 0 after the reset edge. An ack arriving in IDLE is ignored.
- States are IDLE, WAIT, DONE, FAULT.
- IDLE:
  - lsu_valid=1 with legal funct3 and aligned address: register mem_addr, mem_be, mem_wdata and mem_we, plus internal funct3 and addr[1:0]. mem_req=1 from the next cycle; go to WAIT.
  - lsu_valid=1 with illegal funct3 or misaligned address: go to FAULT. No mem_req is issued.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. If funct3 is illegal, only lsu_ill is set (misalign is not checked).
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata=replicated byte.
  - SH: be=0011<<addr[1:0], wdata=replicated halfword.
  - SW: be=1111.
- Loads drive mem_be=1111 and mem_wdata=0.
- WAIT: mem_req and all mem_* outputs are held stable. mem_ack=1 (may arrive the first WAIT cycle) -> capture mem_rdata; go to DONE; mem_req=0 from the next cycle.
- DONE (1 cycle): lsu_done=1.
  - Load: lsu_rdata = lane selected by the saved addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - Store: lsu_rdata=0.
  - Then go to IDLE.
- FAULT (1 cycle): lsu_done=1, the relevant fault flag=1, lsu_rdata=0; then go to IDLE.
- Throughput: minimum latency is valid -> done in 3 cycles (IDLE->WAIT, ack in WAIT, DONE).
- A new lsu_valid is accepted no earlier than the cycle after DONE/FAULT, i.e. back in IDLE. lsu_valid in a non-IDLE state is ignored; the core must hold it until lsu_done.
- Fault flags are 0 whenever lsu_done=0.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack: drop mem_req, go to FAULT with lsu_bus_err=1.
  - An ack in the same cycle as the terminal count wins; the access completes normally.
- Undefined: no counter; WAIT lasts indefinitely; lsu_bus_err is tied to 0.

Test Plan:
1. LB addr=0x1003, mem_rdata=0x80FF_0000, ack 1st WAIT cycle -> mem_addr=0x1000, mem_be=1111, lsu_done on cycle 3, lsu_rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
2. SH addr=0x2002, wdata=0x1234_ABCD, ack after 4 WAIT cycles -> mem_req held 4 cycles, mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x2000, lsu_rdata=0.
3. LW addr=0x3001 -> no mem_req, lsu_done with lsu_misalign=1 next cycle; funct3=011 load -> lsu_ill=1, lsu_misalign=0.
4. rst asserted in WAIT, then ack arrives -> mem_req=0 after the reset edge, no lsu_done, all outputs 0; a following LW addr=0x0 completes normally.
5. lsu_valid held high through a transaction -> exactly one mem_req per transaction; a second transaction starts only after returning to IDLE.
6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> mem_req drops and lsu_bus_err with lsu_done after 8 WAIT cycles; ack at the terminal cycle -> normal completion, lsu_bus_err=0.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I load/store unit fed by the ALU result.
// Aligns store data into byte lanes, builds byte enables, extends load data,
// and runs one access at a time on a req/ack memory port while holding the
// core off through lsu_busy / lsu_done.
// Optional build macro: LSU_TIMEOUT_EN enables the WAIT-state timeout abort
// that reports lsu_bus_err after TIMEOUT_CYCLES cycles without mem_ack.
module lsu_mem_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_valid,
  input  logic            lsu_we,
  input  logic [2:0]      lsu_funct3,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_done,
  output logic            lsu_busy,
  output logic            lsu_misalign,
  output logic            lsu_ill,
  output logic            lsu_bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic              ill_q, ill_d;

  // Request decode
  logic              req_ill, req_mis;
  logic [3:0]        req_be;
  logic [XLEN-1:0]   req_wdata;

  // Load formatting
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;
  assign lsu_bus_err = bus_err_q;
`else
  // No timeout logic in this build; the parameter is kept so both builds share one interface.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_inert
  end
  assign lsu_bus_err = 1'b0;
`endif

  // Classify the incoming request and build its byte lanes.
  always_comb begin
    req_ill   = 1'b0;
    req_mis   = 1'b0;
    req_be    = 4'b1111;
    req_wdata = '0;
    if (lsu_we) begin
      req_ill = (lsu_funct3[2] == 1'b1) || (lsu_funct3[1:0] == 2'b11);
    end else begin
      req_ill = (lsu_funct3 == 3'b011) || (lsu_funct3 == 3'b110) || (lsu_funct3 == 3'b111);
    end
    // Misalignment is only meaningful once the size code is known to be legal.
    if (!req_ill) begin
      case (lsu_funct3[1:0])
        2'b01:   req_mis = lsu_addr[0];
        2'b10:   req_mis = (lsu_addr[1:0] != 2'b00);
        default: req_mis = 1'b0;
      endcase
    end
    if (lsu_we) begin
      case (lsu_funct3[1:0])
        2'b00: begin
          req_be    = 4'b0001 << lsu_addr[1:0];
          req_wdata = {4{lsu_wdata[7:0]}};
        end
        2'b01: begin
          req_be    = 4'b0011 << lsu_addr[1:0];
          req_wdata = {2{lsu_wdata[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = lsu_wdata;
        end
      endcase
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rdata_d     = '0;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    ill_d       = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (lsu_valid) begin
          if (req_ill || req_mis) begin
            state_d    = S_FAULT;
            done_d     = 1'b1;
            ill_d      = req_ill;
            misalign_d = req_mis;
          end else begin
            state_d     = S_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = lsu_we;
            mem_addr_d  = {lsu_addr[31:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata;
            funct3_d    = lsu_funct3;
            off_d       = lsu_addr[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          rdata_d   = mem_we_q ? '0 : ld_ext;
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_FAULT;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      ill_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      ill_q       <= ill_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign lsu_rdata    = rdata_q;
  assign lsu_done     = done_q;
  assign lsu_busy     = (state_q != S_IDLE);
  assign lsu_misalign = misalign_q;
  assign lsu_ill      = ill_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized transactions against a
// behavioural model of the RV32I load/store lane rules.
// Build with +define+LSU_TIMEOUT_EN to also exercise the timeout abort.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_busy;
  logic        lsu_misalign;
  logic        lsu_ill;
  logic        lsu_bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  lsu_mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata),
    .lsu_done(lsu_done), .lsu_busy(lsu_busy), .lsu_misalign(lsu_misalign),
    .lsu_ill(lsu_ill), .lsu_bus_err(lsu_bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock; stimulus changes and sampling happen 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 0 || f3 == 1 || f3 == 2);
    return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    int n;
    n = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return n;
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned v;
    if (!we) return 4'hF;
    v = ((1 << m_size(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input bit we, input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n;
    r = '0;
    if (!we) return r;
    n = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int unsigned sh, mask, v;
    int n;
    n = m_size(f3);
    if (n == 4) return rd;
    sh   = rd >> (8 * (a % 4));
    mask = (1 << (8 * n)) - 1;
    v    = sh & mask;
    if (f3 < 4 && (v >> (8 * n - 1)) % 2 == 1) v = v | ~mask;
    return v;
  endfunction

  // One complete transaction from the IDLE state; returns in IDLE.
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int delay, input bit hold);
    bit legal, mis;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    legal  = m_legal(we, f3);
    mis    = legal && m_misaligned(f3, a);
    e_addr = a & 32'hFFFF_FFFC;
    e_be   = m_be(we, f3, a);
    e_wd   = m_wdata(we, f3, wd);
    e_rd   = we ? 32'h0 : m_load(f3, a, rd);

    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
    tick();
    if (!hold) begin
      lsu_valid = 1'b0;
      lsu_addr = $urandom(); lsu_wdata = $urandom(); lsu_funct3 = 3'($urandom_range(0, 7));
    end

    if (!legal || mis) begin
      chk("fault_req", mem_req, 0);
      chk("fault_done", lsu_done, 1);
      chk("fault_ill", lsu_ill, !legal);
      chk("fault_mis", lsu_misalign, mis);
      chk("fault_rdata", lsu_rdata, 0);
      chk("fault_buserr", lsu_bus_err, 0);
      tick();
    end else begin
      for (int i = 0; i <= delay; i++) begin
        chk("wait_req", mem_req, 1);
        chk("wait_done", lsu_done, 0);
        chk("wait_busy", lsu_busy, 1);
        chk("wait_addr", mem_addr, e_addr);
        chk("wait_be", {28'h0, mem_be}, {28'h0, e_be});
        chk("wait_wdata", mem_wdata, e_wd);
        chk("wait_we", mem_we, we);
        if (i == delay) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end else begin
          mem_rdata = $urandom();
        end
        tick();
        mem_ack = 1'b0; mem_rdata = $urandom();
      end
      chk("done_pulse", lsu_done, 1);
      chk("done_req", mem_req, 0);
      chk("done_rdata", lsu_rdata, e_rd);
      chk("done_flags", {29'h0, lsu_misalign, lsu_ill, lsu_bus_err}, 0);
      chk("done_busy", lsu_busy, 1);
      tick();
    end
    lsu_valid = 1'b0;
    chk("idle_done", lsu_done, 0);
    chk("idle_busy", lsu_busy, 0);
    chk("idle_req", mem_req, 0);
    chk("idle_flags", {29'h0, lsu_misalign, lsu_ill, lsu_bus_err}, 0);
    $display("txn we=%0d f3=%0d addr=0x%08h delay=%0d hold=%0d rdata=0x%08h", we, f3, a, delay, hold, lsu_rdata);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_be"}, {28'h0, mem_be}, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, lsu_rdata, 0);
    chk({tag, "_ctl"}, {27'h0, lsu_done, lsu_busy, lsu_misalign, lsu_ill, lsu_bus_err}, 0);
  endtask

  initial begin
    bit we;
    logic [2:0] f3;
    logic [2:0] legal_ld [5];
    legal_ld[0] = 3'd0; legal_ld[1] = 3'd1; legal_ld[2] = 3'd2; legal_ld[3] = 3'd4; legal_ld[4] = 3'd5;

    rst = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0;
    lsu_addr = '0; lsu_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Directed: sign/zero extended byte loads.
    do_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1'b0);
    chk("lb_result_latched_zero", lsu_rdata, 0);
    do_txn(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1'b0);
    // Directed: SH upper half with a four-cycle request.
    do_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 3, 1'b0);
    // Directed: misaligned LW and illegal load code.
    do_txn(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0);
    do_txn(1'b0, 3'b011, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0);
    do_txn(1'b1, 3'b100, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b0);

    // Reset while waiting for the memory, then a stray ack in IDLE.
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h0000_4000;
    tick();
    lsu_valid = 1'b0;
    chk("rst_pre_req", mem_req, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_wait");
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_done", lsu_done, 0);
    chk("stray_ack_busy", lsu_busy, 0);
    chk("stray_ack_rdata", lsu_rdata, 0);
    do_txn(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h1357_9BDF, 1, 1'b0);

    // Valid held high through whole transactions.
    do_txn(1'b0, 3'b001, 32'h0000_5006, 32'h0, 32'h8001_7FFF, 2, 1'b1);
    do_txn(1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0, 0, 1'b1);

`ifdef LSU_TIMEOUT_EN
    // No ack: abort after eight WAIT cycles.
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h0000_6000;
    tick();
    lsu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_done", lsu_done, 0);
      tick();
    end
    chk("to_done", lsu_done, 1);
    chk("to_bus_err", lsu_bus_err, 1);
    chk("to_req", mem_req, 0);
    chk("to_rdata", lsu_rdata, 0);
    chk("to_other_flags", {30'h0, lsu_misalign, lsu_ill}, 0);
    tick();
    chk("to_idle_busy", lsu_busy, 0);
    chk("to_idle_err", lsu_bus_err, 0);
    $display("txn timeout abort addr=0x00006000");
    // Ack on the terminal cycle completes normally.
    do_txn(1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h2468_ACE0, 7, 1'b0);
`endif

    // Randomized transactions against the model.
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = legal_ld[$urandom_range(0, 4)];
      do_txn(we, f3, $urandom(), $urandom(), $urandom(), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
